// File: rtl/pipeline_register_chain.sv
// pipeline_register_chain
// A chain of DEPTH valid/ready register stages carrying an opcode and a payload.
// Empty stages are filled from behind even while the output is stalled, so
// bubbles collapse. The input ready is passed through combinationally from the
// output side, so a full chain that is released accepts in the same cycle.
// flush drops every in-flight entry. rst clears every register.

module pipeline_register_chain #(
    parameter int DATA_W      = 64,
    parameter int OP_W        = 4,
    parameter int DEPTH       = 2,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            in_opcode,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OP_W-1:0]            out_opcode,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int LAST  = DEPTH - 1;

    logic [DEPTH-1:0]  v_q;
    logic [DEPTH-1:0]  v_d;
    logic [OP_W-1:0]   op_q   [DEPTH];
    logic [OP_W-1:0]   op_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  mv;
    logic [DEPTH-1:0]  load;
    logic              in_xfer;
    logic [OCC_W-1:0]  occ;

    // Move enables: a stage advances when there is room anywhere downstream of it
    // (a hole, or the output draining). Nothing moves during a flush cycle.
    always_comb begin
        logic room;
        room = out_ready;
        mv   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            mv[k] = v_q[k] & room & ~flush;
            room  = room | ~v_q[k];
        end
    end

    assign in_ready = (~v_q[0] | mv[0]) & ~flush & ~rst;
    assign in_xfer  = in_valid & in_ready;

    // Next state: each stage loads from its predecessor (stage 0 from the input),
    // drops its valid bit when it empties, and otherwise holds.
    always_comb begin
        load    = '0;
        v_d     = v_q;
        op_d    = op_q;
        data_d  = data_q;
        load[0] = in_xfer;
        for (int k = 1; k < DEPTH; k++) begin
            load[k] = mv[k-1];
        end
        if (load[0]) begin
            op_d[0]   = in_opcode;
            data_d[0] = in_data;
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (load[k]) begin
                op_d[k]   = op_q[k-1];
                data_d[k] = data_q[k-1];
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            v_d[k] = flush ? 1'b0 : (load[k] | (v_q[k] & ~mv[k]));
        end
    end

    // Stage registers; reset clears valid bits and contents alike.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                op_q[k]   <= '0;
                data_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            op_q   <= op_d;
            data_q <= data_d;
        end
    end

    // Occupancy is the population count of the valid bits.
    always_comb begin
        occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occ = occ + OCC_W'(v_q[k]);
        end
    end

    assign occupancy  = occ;
    assign out_valid  = v_q[LAST] & ~flush & ~rst;
    assign out_opcode = (ZERO_BUBBLE && !out_valid) ? '0 : op_q[LAST];
    assign out_data   = (ZERO_BUBBLE && !out_valid) ? '0 : data_q[LAST];

endmodule

// File: tb/tb_pipeline_register_chain.sv
// Bench for pipeline_register_chain: a DEPTH=2/ZERO_BUBBLE=1 instance checked
// every cycle against a queue model, and a DEPTH=4/ZERO_BUBBLE=0 instance for
// bubble collapse and raw last-stage visibility.

module tb_pipeline_register_chain;

    localparam int AD = 2;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DEPTH=2, 64-bit data, zero bubble
    logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [3:0]  a_in_opcode, a_out_opcode;
    logic [63:0] a_in_data, a_out_data;
    logic [1:0]  a_occupancy;

    pipeline_register_chain #(.DATA_W(64), .OP_W(4), .DEPTH(AD), .ZERO_BUBBLE(1'b1)) u_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_opcode(a_in_opcode), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_opcode(a_out_opcode), .out_data(a_out_data),
        .occupancy(a_occupancy)
    );

    // Instance B: DEPTH=4, 16-bit data, raw last stage shown
    logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0]  b_in_opcode, b_out_opcode;
    logic [15:0] b_in_data, b_out_data;
    logic [2:0]  b_occupancy;

    pipeline_register_chain #(.DATA_W(16), .OP_W(4), .DEPTH(4), .ZERO_BUBBLE(1'b0)) u_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_opcode(b_in_opcode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_opcode(b_out_opcode), .out_data(b_out_data),
        .occupancy(b_occupancy)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model for A: entries in order, each with its stage position.
    // An entry at index i (0 = oldest) can never be further than stage AD-1-i,
    // and each cycle it advances by one towards that limit.
    typedef struct {
        logic [3:0]  op;
        logic [63:0] data;
        int          pos;
    } ent_t;

    ent_t mq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit mdl_ready();
        return !a_rst && !a_flush && ((mq.size() < AD) || a_out_ready);
    endfunction

    task automatic model_edge();
        bit   acc;
        ent_t e;
        int   cap;
        acc = a_in_valid && mdl_ready();
        if (a_rst || a_flush) begin
            mq.delete();
            return;
        end
        if (mq.size() > 0 && mq[0].pos == AD - 1 && a_out_ready) begin
            void'(mq.pop_front());
        end
        for (int i = 0; i < mq.size(); i++) begin
            e     = mq[i];
            cap   = AD - 1 - i;
            e.pos = (e.pos + 1 > cap) ? cap : e.pos + 1;
            mq[i] = e;
        end
        if (acc) begin
            e.op   = a_in_opcode;
            e.data = a_in_data;
            e.pos  = 0;
            mq.push_back(e);
        end
    endtask

    task automatic check_a();
        bit          ev;
        logic [63:0] ed;
        logic [3:0]  eo;
        ev = !a_rst && !a_flush && mq.size() > 0 && mq[0].pos == AD - 1;
        ed = ev ? mq[0].data : 64'd0;
        eo = ev ? mq[0].op : 4'd0;
        chk("a_in_ready", 64'(a_in_ready), 64'(mdl_ready()));
        chk("a_out_valid", 64'(a_out_valid), 64'(ev));
        chk("a_out_data", a_out_data, ed);
        chk("a_out_opcode", 64'(a_out_opcode), 64'(eo));
        chk("a_occupancy", 64'(a_occupancy), 64'(mq.size()));
    endtask

    // One cycle: inputs already applied after the falling edge.
    task automatic tick();
        #1;
        check_a();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_in_opcode = '0; a_in_data = '0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_opcode = '0; b_in_data = '0;

        // Reset
        @(posedge clk);
        @(negedge clk);
        tick();
        a_rst = 1'b0;
        b_rst = 1'b0;
        #1;
        chk("b_rst_occupancy", 64'(b_occupancy), 64'd0);
        chk("b_rst_out_valid", 64'(b_out_valid), 64'd0);
        chk("b_rst_out_data", 64'(b_out_data), 64'd0);
        tick();

        // Streaming op=1..8 / data=0x10..0x17
        a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_in_valid  = 1'b1;
            a_in_opcode = 4'(i + 1);
            a_in_data   = 64'(16 + i);
            tick();
        end
        a_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Fill under stall
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_opcode = 4'd1; a_in_data = 64'h21; tick();
        a_in_opcode = 4'd2; a_in_data = 64'h22; tick();
        a_in_opcode = 4'd3; a_in_data = 64'h23;
        #1;
        chk("stall_in_ready", 64'(a_in_ready), 64'd0);
        chk("stall_occupancy", 64'(a_occupancy), 64'd2);
        tick();
        a_out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(a_in_ready), 64'd1);
        tick();
        a_in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        // Flush of a full chain with an entry on offer
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_opcode = 4'd4; a_in_data = 64'h31; tick();
        a_in_opcode = 4'd5; a_in_data = 64'h32; tick();
        a_flush     = 1'b1;
        a_in_opcode = 4'hF; a_in_data = 64'h3F;
        #1;
        chk("flush_in_ready", 64'(a_in_ready), 64'd0);
        chk("flush_out_valid", 64'(a_out_valid), 64'd0);
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        #1;
        chk("post_flush_occupancy", 64'(a_occupancy), 64'd0);
        chk("post_flush_out_valid", 64'(a_out_valid), 64'd0);
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Zero bubble on an empty chain
        #1;
        chk("zb_out_opcode", 64'(a_out_opcode), 64'd0);
        chk("zb_out_data", a_out_data, 64'd0);

        // Reset mid-stream with two entries in flight
        a_in_valid  = 1'b1;
        a_in_opcode = 4'd6; a_in_data = 64'h41; tick();
        a_in_opcode = 4'd7; a_in_data = 64'h42; tick();
        a_in_valid = 1'b0;
        a_rst      = 1'b1;
        tick();
        a_rst = 1'b0;
        #1;
        chk("rst_mid_occupancy", 64'(a_occupancy), 64'd0);
        chk("rst_mid_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_mid_out_data", a_out_data, 64'd0);
        chk("rst_mid_out_opcode", 64'(a_out_opcode), 64'd0);
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic with occasional flush and reset
        for (int c = 0; c < 400; c++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 31) == 0);
            a_rst       = ($urandom_range(0, 63) == 0);
            a_in_opcode = 4'($urandom);
            a_in_data   = {$urandom, $urandom};
            tick();
        end
        a_flush = 1'b0; a_rst = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Bubble collapse on the DEPTH=4 chain with the output stalled
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_opcode = 4'd5;
        b_in_data   = 16'h00AB;
        tick();
        b_in_valid = 1'b0;
        #1;
        chk("b_occ_stage0", 64'(b_occupancy), 64'd1);
        chk("b_valid_stage0", 64'(b_out_valid), 64'd0);
        tick();
        tick();
        #1;
        chk("b_valid_stage2", 64'(b_out_valid), 64'd0);
        tick();
        #1;
        chk("b_valid_stage3", 64'(b_out_valid), 64'd1);
        chk("b_data_stage3", 64'(b_out_data), 64'h00AB);
        chk("b_opcode_stage3", 64'(b_out_opcode), 64'd5);
        chk("b_occ_stage3", 64'(b_occupancy), 64'd1);

        // Drain, then the raw last stage stays visible
        b_out_ready = 1'b1;
        tick();
        #1;
        chk("b_drained_valid", 64'(b_out_valid), 64'd0);
        chk("b_drained_data", 64'(b_out_data), 64'h00AB);
        chk("b_drained_opcode", 64'(b_out_opcode), 64'd5);
        chk("b_drained_occ", 64'(b_occupancy), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_register_chain.md
PIPELINE_REGISTER_CHAIN -- requirements
Module: pipeline_register_chain

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning payload width in bits (1..256).
REQ-002 The block SHALL have parameter OP_W, default 4, meaning opcode width in bits (1..16).
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning number of register stages (1..8).
REQ-004 The block SHALL have parameter ZERO_BUBBLE, default 1, meaning out_opcode/out_data are forced to 0 whenever out_valid=0.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous kill of all in-flight entries.
REQ-008 The block SHALL have port in_valid, input, 1 bit: upstream offers an entry.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the chain accepts an entry this cycle.
REQ-010 The block SHALL have port in_opcode, input, OP_W bits: opcode of the offered entry.
REQ-011 The block SHALL have port in_data, input, DATA_W bits: payload of the offered entry.
REQ-012 The block SHALL have port out_valid, output, 1 bit: the last stage holds a valid entry.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts; out_ready=0 is a stall.
REQ-014 The block SHALL have port out_opcode, output, OP_W bits: opcode of the last stage.
REQ-015 The block SHALL have port out_data, output, DATA_W bits: payload of the last stage.
REQ-016 The block SHALL have port occupancy, output, $clog2(DEPTH+1) bits: count of valid stages.

Function
REQ-017 Each stage k SHALL hold a valid bit v[k], an OP_W opcode and a DATA_W payload; stage 0 is the input side, stage DEPTH-1 drives the outputs.
REQ-018 Transfers SHALL occur at input when in_valid&in_ready and at output when out_valid&out_ready, both sampled at the same rising edge.
REQ-019 Last-stage move SHALL be mv[DEPTH-1] = v[DEPTH-1] & out_ready; for k<DEPTH-1, stage k moves when v[k] & (~v[k+1] | mv[k+1]).
REQ-020 The block SHALL collapse bubbles: a valid stage advances into an empty successor even while out_ready=0.
REQ-021 in_ready SHALL equal (~v[0] | mv[0]) & ~flush & ~rst, computed combinationally in the same cycle.
REQ-022 Stage 0 SHALL load in_opcode/in_data and set v[0]=1 on an input transfer; a stage that moves and is not refilled SHALL clear its valid bit.
REQ-023 Payload/opcode registers of a stage that neither moves nor loads SHALL hold their value.
REQ-024 Latency SHALL be exactly DEPTH cycles with out_ready held 1: an entry accepted at edge t is presented at out_* after edge t+DEPTH-1 and can transfer at edge t+DEPTH.
REQ-025 Throughput SHALL be one entry per cycle with no bubbles when in_valid=1 and out_ready=1 continuously.
REQ-026 With out_ready=0 the chain SHALL accept until all DEPTH stages are valid, then hold in_ready=0; no entry is dropped, duplicated or reordered.
REQ-027 When the chain is full and out_ready rises, in_ready SHALL be 1 in that same cycle (pass-through of ready).
REQ-028 occupancy SHALL equal the number of set valid bits, ranging 0..DEPTH.
REQ-029 When flush=1 at an edge, all v[k] SHALL clear; in_ready and out_valid SHALL be 0 during the flush cycle, so no transfer occurs that cycle.
REQ-030 When ZERO_BUBBLE=1 and out_valid=0, out_opcode and out_data SHALL be all zeros; when ZERO_BUBBLE=0 they SHALL show the last-stage registers unmodified.
REQ-031 out_valid SHALL be v[DEPTH-1] & ~flush and SHALL not depend combinationally on out_ready.

Reset
REQ-032 While rst=1 at an edge, all valid bits, opcode and payload registers SHALL clear to 0; occupancy=0.
REQ-033 During a cycle with rst=1, in_ready=0 and out_valid=0; reset mid-operation SHALL discard all entries.
REQ-034 rst and flush together SHALL behave as rst.

Verification
REQ-035 The bench SHALL check streaming: DEPTH=2, out_ready=1, entries op=1..8/data=0x10..0x17 on consecutive cycles -> identical sequence out after 2-cycle latency, no gaps.
REQ-036 The bench SHALL check fill under stall: out_ready=0, offer 3 entries -> in_ready=0 after 2 accepts, occupancy=2; release out_ready -> third entry accepted the same cycle, order preserved.
REQ-037 The bench SHALL check bubble collapse: DEPTH=4, one entry in stage 0, out_ready=0 -> entry reaches stage 3 after 3 edges, occupancy stays 1.
REQ-038 The bench SHALL check flush: full chain (occupancy=2), flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, the offered entry not accepted.
REQ-039 The bench SHALL check zero bubble: ZERO_BUBBLE=1, empty chain -> out_opcode=0, out_data=0; ZERO_BUBBLE=0 after a drained entry 0xAB -> out_data still 0xAB with out_valid=0.
REQ-040 The bench SHALL check reset mid-stream: rst=1 for one cycle with 2 entries in flight -> occupancy=0, all outputs 0, no stale entry emitted afterward.
